// File: rtl/ahb_slave_sram_if.sv
// AHB-Lite bus bundle between a master-side driver and the SRAM responder.
// hready is the bus-level ready, driven by the interconnect (master side).
interface ahb_slave_sram_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int HPROT_WIDTH = 4
);
    logic                    hselx;
    logic [ADDR_WIDTH-1:0]   haddr;
    logic [1:0]              htrans;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [HPROT_WIDTH-1:0]  hprot;
    logic [DATA_WIDTH-1:0]   hwdata;
    logic [DATA_WIDTH/8-1:0] hwstrb;
    logic                    hready;
    logic                    hreadyout;
    logic                    hresp;
    logic [DATA_WIDTH-1:0]   hrdata;
    logic                    hexokay;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
        input  hreadyout, hresp, hrdata, hexokay
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
        output hreadyout, hresp, hrdata, hexokay
    );
endinterface

// File: rtl/ahb_slave_sram.sv
// AHB-Lite responder backed by a word-organised SRAM with strobed writes and ERROR on illegal
// accesses. Wait-state insertion is compiled in when AHB_SLAVE_WAIT_STATE_EN is defined.
//
// state | meaning
// IDLE  | ready; completes a pending transfer (if any) and samples the next address phase
// WAIT  | hreadyout low while the wait down-counter runs to terminal count
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high; samples the next address phase
module ahb_slave_sram #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 2
) (
    input logic             hclk_i,
    input logic             hreset_i,
    ahb_slave_sram_if.slave ahb
);
    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NBYTES);
    localparam int IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int OFF_BITS  = LANE_BITS + IDX_BITS;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NBYTES);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB_SLAVE_WAIT_STATE_EN
    localparam bit WAIT_EN = (WAIT_STATES != 0);
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  ph_valid_q, ph_valid_d;
    logic                  ph_write_q, ph_write_d;
    logic [2:0]            ph_size_q, ph_size_d;
    logic [OFF_BITS-1:0]   ph_off_q, ph_off_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic [7:0]            size_mask;
    logic                  accept;
    logic                  out_of_range;
    logic                  size_bad;
    logic                  misaligned;
    logic                  illegal;
    logic                  hreadyout_c;
    logic                  hresp_c;
    logic                  complete;
    logic                  commit;
    logic [IDX_BITS-1:0]   ph_idx;
    logic [NBYTES-1:0]     wr_be;
    logic                  unused_bits;

    // Address-phase decode; BASE_ADDR is lane-aligned so haddr alignment equals offset alignment.
    assign accept       = ahb.hselx & ahb.hready & ahb.htrans[1];
    assign offset       = ahb.haddr - BASE_ADDR;
    assign out_of_range = ({1'b0, offset} >= MEM_BYTES);
    assign size_bad     = (ahb.hsize > 3'(LANE_BITS));
    assign size_mask    = (8'd1 << ahb.hsize) - 8'd1;
    assign misaligned   = |(ahb.haddr[LANE_BITS-1:0] & size_mask[LANE_BITS-1:0]);
    assign illegal      = out_of_range | size_bad | misaligned;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ph_valid_d  = ph_valid_q;
        ph_write_d  = ph_write_q;
        ph_size_d   = ph_size_q;
        ph_off_d    = ph_off_q;
        hreadyout_c = 1'b1;
        hresp_c     = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                hresp_c = (state_q == ST_ERR2);
                state_d = ST_IDLE;
                if (ahb.hready) begin
                    ph_valid_d = 1'b0;
                    if (accept) begin
                        if (illegal) begin
                            state_d = ST_ERR1;
                        end else begin
                            ph_valid_d = 1'b1;
                            ph_write_d = ahb.hwrite;
                            ph_size_d  = ahb.hsize;
                            ph_off_d   = offset[OFF_BITS-1:0];
                            if (WAIT_EN) begin
                                state_d    = ST_WAIT;
                                wait_cnt_d = WAIT_LOAD;
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                hreadyout_c = 1'b0;
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 1'b1;
                state_d     = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ph_valid_q <= 1'b0;
            ph_write_q <= 1'b0;
            ph_size_q  <= '0;
            ph_off_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ph_valid_q <= ph_valid_d;
            ph_write_q <= ph_write_d;
            ph_size_q  <= ph_size_d;
            ph_off_q   <= ph_off_d;
        end
    end

    // A legal transfer completes in the first IDLE cycle after its address phase or wait states.
    assign complete = (state_q == ST_IDLE) & ph_valid_q;
    assign commit   = complete & ph_write_q & ~hreset_i;
    assign ph_idx   = ph_off_q[OFF_BITS-1:LANE_BITS];

    // Lane i belongs to the transfer when it sits in the same 2^size block as the latched address.
    always_comb begin
        wr_be = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (((LANE_BITS)'(i) >> ph_size_q) == (ph_off_q[LANE_BITS-1:0] >> ph_size_q)) begin
                wr_be[i] = ahb.hwstrb[i];
            end
        end
    end

    always_ff @(posedge hclk_i) begin
        if (commit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem_q[ph_idx][i*8 +: 8] <= ahb.hwdata[i*8 +: 8];
                end
            end
        end
    end

    assign ahb.hreadyout = hreadyout_c;
    assign ahb.hresp     = hresp_c;
    assign ahb.hrdata    = (complete & ~ph_write_q) ? mem_q[ph_idx] : '0;
    assign ahb.hexokay   = 1'b0;

    assign unused_bits = ^{ahb.hburst, ahb.hprot, ahb.htrans[0],
                           offset[ADDR_WIDTH-1:OFF_BITS], size_mask[7:LANE_BITS]};
endmodule

// File: tb/tb_ahb_slave_sram.sv
// Randomised bench for ahb_slave_sram: pipelined AHB master driver plus a byte-array memory model.
module tb_ahb_slave_sram;
    localparam int          AW        = 32;
    localparam int          DW        = 32;
    localparam int          HPW       = 4;
    localparam int          DEPTH     = 256;
    localparam int          WS        = 2;
    localparam int          MEM_BYTES = DEPTH * 4;
    localparam logic [31:0] BASE      = 32'h0000_2000;
`ifdef AHB_SLAVE_WAIT_STATE_EN
    localparam int EXP_WAIT = WS;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        seq;
    } xfer_t;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_slave_sram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HPROT_WIDTH(HPW)) ahb ();
    assign ahb.hready = ahb.hreadyout;

    ahb_slave_sram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)
    ) dut (
        .hclk_i  (hclk),
        .hreset_i(hreset),
        .ahb     (ahb)
    );

    int          total;
    int          bad;
    xfer_t       xq[$];
    int          obs_cyc[$];
    logic        obs_first[$];
    logic        obs_resp[$];
    logic [31:0] obs_rdata[$];
    int          seq_cycles;
    bit          timed_out;
    logic [7:0]  ref_mem [MEM_BYTES];

    function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [3:0] wstrb, input logic seq);
        xfer_t x;
        x.addr = addr; x.write = write; x.size = size;
        x.wdata = wdata; x.wstrb = wstrb; x.seq = seq;
        return x;
    endfunction

    // Reference behaviour of one transfer, applied in bus order.
    function automatic void model_step(input xfer_t x, output int cyc, output logic first,
                                       output logic resp, output logic [31:0] rdata);
        logic [31:0] off;
        int nb;
        int lane;
        off   = x.addr - BASE;
        nb    = 1 << x.size;
        rdata = '0;
        if (off >= MEM_BYTES || x.size > 2 || (x.addr % nb) != 0) begin
            cyc = 2; first = 1'b1; resp = 1'b1;
            return;
        end
        cyc = 1 + EXP_WAIT; first = 1'b0; resp = 1'b0;
        if (x.write) begin
            for (int b = 0; b < nb; b++) begin
                lane = int'((off + b) % 4);
                if (x.wstrb[lane]) ref_mem[off + b] = x.wdata[lane*8 +: 8];
            end
        end else begin
            for (int b = 0; b < 4; b++) rdata[b*8 +: 8] = ref_mem[(off & ~32'h3) + b];
        end
    endfunction

    task automatic drive_idle();
        ahb.hselx = 1'b0; ahb.htrans = 2'b00; ahb.haddr = '0; ahb.hwrite = 1'b0;
        ahb.hsize = 3'd0; ahb.hburst = 3'd0; ahb.hprot = '0;
    endtask

    task automatic drive_addr(input int i);
        if (i < xq.size()) begin
            ahb.hselx  = 1'b1;
            ahb.htrans = xq[i].seq ? 2'b11 : 2'b10;
            ahb.haddr  = xq[i].addr;
            ahb.hwrite = xq[i].write;
            ahb.hsize  = xq[i].size;
            ahb.hburst = 3'b001;
            ahb.hprot  = 4'h3;
        end else begin
            drive_idle();
        end
    endtask

    // Pipelined master: runs xq and records what each data phase looked like.
    task automatic run_xfers();
        int   a_idx, d_idx, cur_cyc, guard;
        bit   have_d;
        logic ready, cur_first;
        obs_cyc.delete(); obs_first.delete(); obs_resp.delete(); obs_rdata.delete();
        seq_cycles = 0; timed_out = 0;
        a_idx = 0; d_idx = 0; cur_cyc = 0; have_d = 0; guard = 0; cur_first = 1'b0;
        @(posedge hclk); #1;
        drive_addr(0);
        while ((a_idx < xq.size() || have_d) && !timed_out) begin
            @(negedge hclk);
            seq_cycles++;
            ready = ahb.hreadyout;
            if (have_d) begin
                cur_cyc++;
                if (cur_cyc == 1) cur_first = ahb.hresp;
                if (ready) begin
                    obs_cyc.push_back(cur_cyc);
                    obs_first.push_back(cur_first);
                    obs_resp.push_back(ahb.hresp);
                    obs_rdata.push_back(ahb.hrdata);
                    have_d = 0;
                end
            end
            @(posedge hclk); #1;
            if (ready && a_idx < xq.size()) begin
                d_idx = a_idx; a_idx++; have_d = 1; cur_cyc = 0;
                ahb.hwdata = xq[d_idx].wdata;
                ahb.hwstrb = xq[d_idx].wstrb;
                drive_addr(a_idx);
            end
            guard++;
            if (guard > 20 * xq.size() + 20) timed_out = 1;
        end
        drive_idle();
        ahb.hwdata = '0; ahb.hwstrb = '0;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        drive_idle();
        ahb.hwdata = '0; ahb.hwstrb = '0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        total++;
        if ({ahb.hreadyout, ahb.hresp, ahb.hexokay} !== 3'b100) begin
            bad++;
            $display("FAIL reset ready/resp/exokay: got %b%b%b want 100", ahb.hreadyout, ahb.hresp, ahb.hexokay);
        end
        total++;
        if (ahb.hrdata !== 32'h0) begin
            bad++;
            $display("FAIL reset hrdata: got %h want 0", ahb.hrdata);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
    endtask

    task automatic test_init_mem();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        xq.delete();
        for (int w = 0; w < DEPTH; w++) xq.push_back(mk(BASE + 32'(4 * w), 1'b1, 3'd2, $urandom, 4'hF, w[0]));
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL init completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL init[%0d] cycles/resp: got %0d/%b want %0d/%b", k, obs_cyc[k], obs_resp[k], e_cyc, e_resp);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        xq.delete();
        xq.push_back(mk(BASE + 32'd4, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0));
        xq.push_back(mk(BASE + 32'd4, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL word_rw completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_first[k] !== e_first || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL word_rw[%0d] cycles/resp: got %0d/%b/%b want %0d/%b/%b", k, obs_cyc[k], obs_first[k], obs_resp[k], e_cyc, e_first, e_resp);
                end
                total++;
                if (obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL word_rw[%0d] hrdata: got %h want %h", k, obs_rdata[k], e_rdata);
                end
            end
        end
        total++;
        if (obs_rdata.size() < 2 || obs_rdata[1] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL word_rw readback: got %h want deadbeef", (obs_rdata.size() > 1) ? obs_rdata[1] : 32'hx);
        end
    endtask

    task automatic test_byte_lane();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        xq.delete();
        xq.push_back(mk(BASE + 32'd6, 1'b1, 3'd0, 32'h005A_0000, 4'h4, 1'b0));
        xq.push_back(mk(BASE + 32'd4, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL byte_lane completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_resp[k] !== e_resp || obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL byte_lane[%0d]: got %0d/%b/%h want %0d/%b/%h", k, obs_cyc[k], obs_resp[k], obs_rdata[k], e_cyc, e_resp, e_rdata);
                end
            end
        end
        total++;
        if (obs_rdata.size() < 2 || obs_rdata[1] !== 32'hDE5ABEEF) begin
            bad++;
            $display("FAIL byte_lane readback: got %h want de5abeef", (obs_rdata.size() > 1) ? obs_rdata[1] : 32'hx);
        end
    endtask

    task automatic test_error_oob();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        xq.delete();
        xq.push_back(mk(BASE + 32'h400, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        xq.push_back(mk(BASE + 32'h400, 1'b1, 3'd2, 32'h1234_5678, 4'hF, 1'b0));
        xq.push_back(mk(BASE - 32'd4, 1'b1, 3'd2, 32'h8765_4321, 4'hF, 1'b0));
        xq.push_back(mk(BASE + 32'h3FC, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        xq.push_back(mk(BASE + 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL error_oob completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_first[k] !== e_first || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL error_oob[%0d] cycles/resp: got %0d/%b/%b want %0d/%b/%b", k, obs_cyc[k], obs_first[k], obs_resp[k], e_cyc, e_first, e_resp);
                end
                total++;
                if (obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL error_oob[%0d] hrdata: got %h want %h", k, obs_rdata[k], e_rdata);
                end
            end
        end
    endtask

    task automatic test_error_misaligned();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        xq.delete();
        xq.push_back(mk(BASE + 32'd1, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 1'b0));
        xq.push_back(mk(BASE + 32'd2, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 1'b0));
        xq.push_back(mk(BASE + 32'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, 1'b0));
        xq.push_back(mk(BASE + 32'd0, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL misaligned completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_first[k] !== e_first || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL misaligned[%0d] cycles/resp: got %0d/%b/%b want %0d/%b/%b", k, obs_cyc[k], obs_first[k], obs_resp[k], e_cyc, e_first, e_resp);
                end
                total++;
                if (obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL misaligned[%0d] hrdata: got %h want %h", k, obs_rdata[k], e_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        int e_total;
        xq.delete();
        for (int b = 0; b < 4; b++) xq.push_back(mk(BASE + 32'h40 + 32'(4 * b), 1'b1, 3'd2, $urandom, 4'hF, b != 0));
        for (int b = 0; b < 4; b++) xq.push_back(mk(BASE + 32'h40 + 32'(4 * b), 1'b0, 3'd2, 32'h0, 4'h0, b != 0));
        run_xfers();
        e_total = 1;
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL burst completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            e_total += e_cyc;
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL burst[%0d] cycles/resp: got %0d/%b want %0d/%b", k, obs_cyc[k], obs_resp[k], e_cyc, e_resp);
                end
                total++;
                if (obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL burst[%0d] hrdata: got %h want %h", k, obs_rdata[k], e_rdata);
                end
            end
        end
        total++;
        if (seq_cycles != e_total) begin
            bad++;
            $display("FAIL burst total cycles: got %0d want %0d", seq_cycles, e_total);
        end
    endtask

    task automatic test_random();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        logic [31:0] addr;
        logic [2:0]  size;
        int          sel;
        xq.delete();
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 9);
            size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (sel == 0)      addr = BASE + 32'h400 + 32'($urandom_range(0, 15));
            else if (sel == 1) addr = BASE - 32'($urandom_range(1, 8));
            else if (sel == 2) addr = BASE + 32'h3F0 + 32'($urandom_range(0, 15));
            else               addr = BASE + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && size < 3) addr = addr & ~((32'd1 << size) - 32'd1);
            xq.push_back(mk(addr, 1'($urandom_range(0, 1)), size, $urandom, 4'($urandom), 1'($urandom_range(0, 1))));
        end
        run_xfers();
        total++;
        if (timed_out || obs_cyc.size() != xq.size()) begin
            bad++;
            $display("FAIL random completions: got %0d want %0d", obs_cyc.size(), xq.size());
        end
        for (int k = 0; k < xq.size(); k++) begin
            model_step(xq[k], e_cyc, e_first, e_resp, e_rdata);
            if (k < obs_cyc.size()) begin
                total++;
                if (obs_cyc[k] != e_cyc || obs_first[k] !== e_first || obs_resp[k] !== e_resp) begin
                    bad++;
                    $display("FAIL random[%0d] a=%h sz=%0d cycles/resp: got %0d/%b/%b want %0d/%b/%b", k, xq[k].addr, xq[k].size, obs_cyc[k], obs_first[k], obs_resp[k], e_cyc, e_first, e_resp);
                end
                total++;
                if (obs_rdata[k] !== e_rdata) begin
                    bad++;
                    $display("FAIL random[%0d] a=%h hrdata: got %h want %h", k, xq[k].addr, obs_rdata[k], e_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_xfer();
        int e_cyc; logic e_first, e_resp; logic [31:0] e_rdata;
        logic [31:0] old_word;
        for (int b = 0; b < 4; b++) old_word[b*8 +: 8] = ref_mem[36 + b];
        @(posedge hclk); #1;
        ahb.hselx = 1'b1; ahb.htrans = 2'b10; ahb.haddr = BASE + 32'd36;
        ahb.hwrite = 1'b1; ahb.hsize = 3'd2; ahb.hburst = 3'b001;
        @(posedge hclk); #1;
        drive_idle();
        ahb.hwdata = ~old_word; ahb.hwstrb = 4'hF;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        total++;
        if ({ahb.hreadyout, ahb.hresp} !== 2'b10 || ahb.hrdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid outputs: got ready=%b resp=%b rdata=%h want 1 0 0", ahb.hreadyout, ahb.hresp, ahb.hrdata);
        end
        ahb.hwdata = '0; ahb.hwstrb = '0;
        xq.delete();
        xq.push_back(mk(BASE + 32'd36, 1'b0, 3'd2, 32'h0, 4'h0, 1'b0));
        run_xfers();
        model_step(xq[0], e_cyc, e_first, e_resp, e_rdata);
        total++;
        if (obs_rdata.size() != 1 || obs_rdata[0] !== e_rdata || obs_resp[0] !== e_resp) begin
            bad++;
            $display("FAIL reset_mid readback: got %h want %h", (obs_rdata.size() > 0) ? obs_rdata[0] : 32'hx, e_rdata);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_init_mem();
        test_word_rw();
        test_byte_lane();
        test_error_oob();
        test_error_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_xfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
